// File: rtl/display_timer_scan.sv
// MM:SS BCD countdown timer driven by divider square waves (sampled as data),
// multiplexed onto a 4-digit common-anode 7-segment display.
module display_timer_scan #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clock_in,
  input  logic        reset_n,
  input  logic        scan_wave_in,
  input  logic        sec_wave_in,
  input  logic        start,
  input  logic        stop,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [3:0]  digit_sel,
  output logic [6:0]  segments,
  output logic        dp,
  output logic        running,
  output logic        done
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned DIG_W = 4;

  // XOR masks that flip the active-low encoding when pins are active-high
  localparam logic [DIG_W-1:0] DIG_INV = {DIG_W{~SEG_ACTIVE_LOW}};
  localparam logic [SEG_W-1:0] SEG_INV = {SEG_W{~SEG_ACTIVE_LOW}};
  localparam logic             DP_INV  = ~SEG_ACTIVE_LOW;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  logic [SYNC_STAGES-1:0] scan_sync_q, sec_sync_q;
  logic                   scan_edge_q, sec_edge_q;
  logic                   scan_tick, sec_tick, sec_level;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d, count_dec;
  logic                   running_q, done_q;
  logic [1:0]             idx_q;

  logic [DIG_W-1:0]       digit_sel_q, digit_sel_d;
  logic [SEG_W-1:0]       segments_q, segments_d;
  logic                   dp_q, dp_d;
  logic [3:0]             cur_digit;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [CNT_W-1:0] clamp_load(input logic [CNT_W-1:0] v);
    logic [3:0] st;
    st = (v[7:4] > 4'd5) ? 4'd5 : v[7:4];
    return {clamp9(v[15:12]), clamp9(v[11:8]), st, clamp9(v[3:0])};
  endfunction

  function automatic logic [CNT_W-1:0] bcd_dec(input logic [CNT_W-1:0] c);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = c;
    if (su != 4'd0) su = su - 4'd1;
    else begin
      su = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        if (mu != 4'd0) mu = mu - 4'd1;
        else begin
          mu = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes blank
  function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Wave synchronizers and rising-edge detectors
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      scan_sync_q <= '0;
      sec_sync_q  <= '0;
      scan_edge_q <= 1'b0;
      sec_edge_q  <= 1'b0;
    end else begin
      scan_sync_q <= {scan_sync_q[SYNC_STAGES-2:0], scan_wave_in};
      sec_sync_q  <= {sec_sync_q[SYNC_STAGES-2:0], sec_wave_in};
      scan_edge_q <= scan_sync_q[SYNC_STAGES-1];
      sec_edge_q  <= sec_sync_q[SYNC_STAGES-1];
    end
  end

  assign sec_level = sec_sync_q[SYNC_STAGES-1];
  assign scan_tick = scan_sync_q[SYNC_STAGES-1] & ~scan_edge_q;
  assign sec_tick  = sec_level & ~sec_edge_q;
  assign count_dec = bcd_dec(count_q);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

  // Priority: load > stop > start > sec tick
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (load) begin
      count_d = clamp_load(load_value);
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, PAUSE: begin
          if (!stop && start && (count_q != '0)) state_d = RUN;
        end
        RUN: begin
          if (stop) state_d = PAUSE;
          else if (sec_tick) begin
            count_d = count_dec;
            if (count_dec == '0) state_d = DONE;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) idx_q <= 2'd0;
    else if (scan_tick) idx_q <= idx_q + 2'd1;
  end

  // Display decode built active-low, then polarity-adjusted
  always_comb begin
    cur_digit   = count_q[{idx_q, 2'b00} +: 4];
    digit_sel_d = ~(DIG_W'(1) << idx_q);
    segments_d  = seg_decode(cur_digit);
    dp_d        = (idx_q != 2'd2);
    if ((state_q == DONE) && !sec_level) begin
      segments_d = '1;
      dp_d       = 1'b1;
    end
    digit_sel_d = digit_sel_d ^ DIG_INV;
    segments_d  = segments_d ^ SEG_INV;
    dp_d        = dp_d ^ DP_INV;
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      digit_sel_q <= 4'b1110 ^ DIG_INV;
      segments_q  <= 7'b1000000 ^ SEG_INV;
      dp_q        <= 1'b1 ^ DP_INV;
    end else begin
      digit_sel_q <= digit_sel_d;
      segments_q  <= segments_d;
      dp_q        <= dp_d;
    end
  end

  assign digit_sel = digit_sel_q;
  assign segments  = segments_q;
  assign dp        = dp_q;
  assign running   = running_q;
  assign done      = done_q;

endmodule

// File: tb/tb_display_timer_scan.sv
// Directed, table-driven bench for display_timer_scan; count is observed through the scanned display.
module tb_display_timer_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_wave, sec_wave, start, stop, load;
  logic [15:0] load_value;
  logic [3:0]  digit_sel;
  logic [6:0]  segments;
  logic        dp, running, done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] ld;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];
  logic [3:0] sel_seq[5];

  always #5 clk = ~clk;

  display_timer_scan #(.SYNC_STAGES(2), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clock_in    (clk),
    .reset_n     (rst_n),
    .scan_wave_in(scan_wave),
    .sec_wave_in (sec_wave),
    .start       (start),
    .stop        (stop),
    .load        (load),
    .load_value  (load_value),
    .digit_sel   (digit_sel),
    .segments    (segments),
    .dp          (dp),
    .running     (running),
    .done        (done)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic scan_pulse();
    @(posedge clk); #1 scan_wave = 1'b1;
    repeat (3) @(posedge clk);
    #1 scan_wave = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic sec_pulse();
    @(posedge clk); #1 sec_wave = 1'b1;
    repeat (4) @(posedge clk);
    #1 sec_wave = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    @(posedge clk); #1 load = 1'b1; load_value = v;
    @(posedge clk); #1 load = 1'b0;
    @(negedge clk);
  endtask

  // Walk all four digits, checking segments/dp for the expected BCD count
  task automatic check_display(input logic [15:0] exp, input string nm);
    for (int k = 0; k < 4; k++) begin
      int idx;
      logic [3:0] d;
      @(negedge clk);
      case (digit_sel)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx < 0) begin
        chk({nm, " digit_sel onehot"}, 16'(digit_sel), 16'hE);
      end else begin
        d = exp[idx*4 +: 4];
        chk($sformatf("%s seg[%0d]", nm, idx), 16'(segments), 16'(seg_of(d)));
        chk($sformatf("%s dp[%0d]", nm, idx), 16'(dp), (idx == 2) ? 16'd0 : 16'd1);
      end
      scan_pulse();
    end
  endtask

  task automatic check_blank(input string nm);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk({nm, " seg dark"}, 16'(segments), 16'h7F);
      chk({nm, " dp dark"}, 16'(dp), 16'd1);
      scan_pulse();
    end
  endtask

  initial begin
    vecs[0] = '{16'h0102, 16'h0102};
    vecs[1] = '{16'hAB7C, 16'h9959};
    vecs[2] = '{16'h5960, 16'h5950};
    vecs[3] = '{16'hFFFF, 16'h9959};
    vecs[4] = '{16'h8765, 16'h8755};
    vecs[5] = '{16'h1234, 16'h1234};
    sel_seq[0] = 4'b1110; sel_seq[1] = 4'b1101; sel_seq[2] = 4'b1011;
    sel_seq[3] = 4'b0111; sel_seq[4] = 4'b1110;

    rst_n = 1'b0; scan_wave = 1'b0; sec_wave = 1'b0;
    start = 1'b0; stop = 1'b0; load = 1'b0; load_value = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst digit_sel", 16'(digit_sel), 16'hE);
    chk("rst segments", 16'(segments), 16'h40);
    chk("rst dp", 16'(dp), 16'd1);
    chk("rst running", 16'(running), 16'd0);
    chk("rst done", 16'(done), 16'd0);

    // Scan sequence after reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("scan sel[%0d]", i), 16'(digit_sel), 16'(sel_seq[i]));
      chk($sformatf("scan dp[%0d]", i), 16'(dp), (sel_seq[i] == 4'b1011) ? 16'd0 : 16'd1);
      chk($sformatf("scan seg[%0d]", i), 16'(segments), 16'h40);
      if (i < 4) scan_pulse();
    end

    // Start with zero count is ignored
    pulse_start();
    chk("start zero running", 16'(running), 16'd0);

    // Load clamp vectors
    foreach (vecs[i]) begin
      do_load(vecs[i].ld);
      chk($sformatf("vec%0d running", i), 16'(running), 16'd0);
      check_display(vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Countdown with borrow across the minute boundary
    do_load(16'h0102);
    pulse_start();
    chk("cd running", 16'(running), 16'd1);
    sec_pulse(); check_display(16'h0101, "cd1");
    sec_pulse(); check_display(16'h0100, "cd2");
    sec_pulse(); check_display(16'h0059, "cd3");
    chk("cd running after", 16'(running), 16'd1);

    // Stop in the same cycle as a sec tick
    @(posedge clk); #1 sec_wave = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk);
    chk("stop+tick running", 16'(running), 16'd0);
    repeat (3) @(posedge clk);
    #1 sec_wave = 1'b0;
    repeat (4) @(posedge clk);
    check_display(16'h0059, "stop+tick");
    pulse_start();
    chk("resume running", 16'(running), 16'd1);
    sec_pulse(); check_display(16'h0058, "resume");

    // Wave held high: a single decrement
    @(posedge clk); #1 sec_wave = 1'b1;
    repeat (1000) @(posedge clk);
    #1 sec_wave = 1'b0;
    repeat (4) @(posedge clk);
    check_display(16'h0057, "held");

    // Run to DONE, blink, start ignored
    do_load(16'h0002);
    pulse_start();
    sec_pulse(); check_display(16'h0001, "done1");
    chk("pre-done done", 16'(done), 16'd0);
    sec_pulse();
    @(negedge clk);
    chk("done flag", 16'(done), 16'd1);
    chk("done running", 16'(running), 16'd0);
    check_blank("done blink");
    pulse_start();
    chk("done after start", 16'(done), 16'd1);
    @(posedge clk); #1 sec_wave = 1'b1;
    repeat (4) @(posedge clk);
    check_display(16'h0000, "done lit");
    chk("done still", 16'(done), 16'd1);
    @(posedge clk); #1 sec_wave = 1'b0;
    repeat (4) @(posedge clk);

    // Load beats start in the same cycle
    @(posedge clk); #1 load = 1'b1; start = 1'b1; load_value = 16'hAB7C;
    @(posedge clk); #1 load = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("load+start running", 16'(running), 16'd0);
    chk("load+start done", 16'(done), 16'd0);
    check_display(16'h9959, "load+start");
    pulse_start();
    chk("after load start", 16'(running), 16'd1);

    // Reset mid-RUN, then scan wave rising one cycle after release
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst running", 16'(running), 16'd0);
    chk("midrst digit_sel", 16'(digit_sel), 16'hE);
    chk("midrst segments", 16'(segments), 16'h40);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 scan_wave = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("tick latency early", 16'(digit_sel), 16'hE);
    @(negedge clk);
    chk("tick latency", 16'(digit_sel), 16'hD);
    #1 scan_wave = 1'b0;
    repeat (3) @(posedge clk);
    check_display(16'h0000, "after midrst");
    chk("after midrst running", 16'(running), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
